rc4_stream_xor: RTL

- Consumer end of the RC4 keystream generator: requests a keystream block, captures the NUMS_OF_BYTES-byte keystream word and XORs it byte-by-byte onto a valid/ready data stream.
- Encrypt and decrypt are the same operation.
- Sits between the keystream generator (start/done/ckey) and the payload datapath.
- Once the captured keystream is used up, the block flags exhaustion and blocks further input until reset.

---
 rtl/rc4_pkg.sv | 18 +
 rtl/rc4_xor_stage.sv | 55 +++++
 rtl/rc4_stream_xor.sv | 133 +++++++++++++
 3 files changed

// File: rtl/rc4_pkg.sv
// Shared types and constants for the RC4 keystream consumer (rc4_stream_xor).
package rc4_pkg;

    localparam int unsigned BYTE_W = 8;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StRun,
        StExhausted
    } rc4_state_e;

    // The byte index must be able to hold n itself (the exhausted position).
    function automatic int unsigned idx_width(input int unsigned n);
        return (n + 1 > 1) ? $clog2(n + 1) : 1;
    endfunction

endpackage

// File: rtl/rc4_xor_stage.sv
// Single-entry valid/ready output register that XORs a payload byte with a keystream byte.
module rc4_xor_stage
    import rc4_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              acc_i,
    input  logic [BYTE_W-1:0] data_i,
    input  logic [BYTE_W-1:0] key_i,
    input  logic              last_i,
    input  logic              out_ready_i,
    output logic              can_accept_o,
    output logic              out_valid_o,
    output logic [BYTE_W-1:0] out_data_o,
    output logic              out_last_o
);

    logic              valid_q, valid_d;
    logic [BYTE_W-1:0] data_q, data_d;
    logic              last_q, last_d;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        last_d  = last_q;
        // A new byte may overwrite the one being drained in the same cycle.
        if (acc_i) begin
            valid_d = 1'b1;
            data_d  = data_i ^ key_i;
            last_d  = last_i;
        end else if (out_ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        can_accept_o = !valid_q || out_ready_i;
        out_valid_o  = valid_q;
        out_data_o   = data_q;
        out_last_o   = last_q;
    end

endmodule

// File: rtl/rc4_stream_xor.sv
// RC4 keystream consumer: fetches one keystream word and XORs it onto a byte stream.
// Build option: define RC4_DROP_EN to add DROP_N and discard the first DROP_N keystream bytes.
module rc4_stream_xor
    import rc4_pkg::*;
#(
    parameter int unsigned NUMS_OF_BYTES = 4
`ifdef RC4_DROP_EN
    ,
    parameter int unsigned DROP_N = 1
`endif
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic                            go_i,
    output logic                            ks_start_o,
    input  logic                            ks_done_i,
    input  logic [NUMS_OF_BYTES*BYTE_W-1:0] ks_data_i,
    input  logic                            in_valid_i,
    output logic                            in_ready_o,
    input  logic [BYTE_W-1:0]               in_data_i,
    input  logic                            in_last_i,
    output logic                            out_valid_o,
    input  logic                            out_ready_i,
    output logic [BYTE_W-1:0]               out_data_o,
    output logic                            out_last_o,
    output logic                            busy_o,
    output logic                            ks_exhausted_o
);

    localparam int unsigned IDX_W = idx_width(NUMS_OF_BYTES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUMS_OF_BYTES);
`ifdef RC4_DROP_EN
    localparam logic [IDX_W-1:0] START_IDX = IDX_W'(DROP_N);
`else
    localparam logic [IDX_W-1:0] START_IDX = '0;
`endif

    rc4_state_e                      state_q, state_d;
    logic                            ks_start_q, ks_start_d;
    logic [IDX_W-1:0]                idx_q, idx_d;
    logic [NUMS_OF_BYTES*BYTE_W-1:0] buf_q, buf_d;

    logic              can_accept;
    logic              in_ready;
    logic              accept;
    logic [BYTE_W-1:0] key_byte;

    always_comb begin
        key_byte = '0;
        for (int unsigned b = 0; b < NUMS_OF_BYTES; b++) begin
            if (idx_q == IDX_W'(b)) begin
                key_byte = buf_q[b*BYTE_W +: BYTE_W];
            end
        end
    end

    always_comb begin
        in_ready = (state_q == StRun) && can_accept && (idx_q < LAST_IDX);
        accept   = in_valid_i && in_ready;
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        buf_d   = buf_q;
        unique case (state_q)
            StIdle: begin
                if (go_i) begin
                    state_d = StReq;
                end
            end
            StReq: begin
                // ks_done may already be high (sticky); capture on the first REQ cycle.
                if (ks_done_i) begin
                    buf_d   = ks_data_i;
                    idx_d   = START_IDX;
                    state_d = StRun;
                end
            end
            StRun: begin
                if (accept) begin
                    idx_d = idx_q + IDX_W'(1);
                    if (idx_q + IDX_W'(1) == LAST_IDX) begin
                        state_d = StExhausted;
                    end
                end
            end
            StExhausted: begin
                state_d = StExhausted;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
        ks_start_d = (state_d == StReq);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= StIdle;
            ks_start_q <= 1'b0;
            idx_q      <= '0;
            buf_q      <= '0;
        end else begin
            state_q    <= state_d;
            ks_start_q <= ks_start_d;
            idx_q      <= idx_d;
            buf_q      <= buf_d;
        end
    end

    rc4_xor_stage u_xor_stage (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .acc_i        (accept),
        .data_i       (in_data_i),
        .key_i        (key_byte),
        .last_i       (in_last_i),
        .out_ready_i  (out_ready_i),
        .can_accept_o (can_accept),
        .out_valid_o  (out_valid_o),
        .out_data_o   (out_data_o),
        .out_last_o   (out_last_o)
    );

    always_comb begin
        ks_start_o     = ks_start_q;
        in_ready_o     = in_ready;
        busy_o         = (state_q == StReq) || (state_q == StRun);
        ks_exhausted_o = (state_q == StExhausted);
    end

endmodule
